// File: rtl/rs_enc_pkg.sv
// Shared definitions for the RS(544,522) GF(2^10) systematic encoder:
// code geometry, generator taps, constant GF multiply and the framing FSM states.
package rs_enc_pkg;

  localparam int W = 10;
  localparam int N = 544;
  localparam int K = 522;
  localparam int R = N - K;

  // Field polynomial x^10 + x^3 + 1; only the bits below x^10 are needed for reduction.
  localparam logic [W-1:0] GF_POLY_LO = 10'h009;

  localparam logic [W-1:0] G [R] = '{
    10'd807, 10'd280, 10'd944, 10'd621, 10'd3,   10'd177, 10'd365, 10'd657,
    10'd813, 10'd1010, 10'd712, 10'd466, 10'd374, 10'd544, 10'd374, 10'd482,
    10'd555, 10'd976, 10'd452, 10'd899, 10'd783, 10'd513
  };

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_e;

  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] acc;
    logic [W-1:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < W; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x[W-1] ? ({x[W-2:0], 1'b0} ^ GF_POLY_LO) : {x[W-2:0], 1'b0};
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs_lfsr_lstep.sv
// Combinational L-step look-ahead of the RS parity LFSR; slot 0 is shifted in first.
module rs_lfsr_lstep
  import rs_enc_pkg::*;
#(
  parameter int L = 8
) (
  input  logic [R-1:0][W-1:0] rem_in,
  input  logic [L-1:0][W-1:0] syms,
  output logic [R-1:0][W-1:0] rem_out
);

  logic [R-1:0][W-1:0] st;
  logic [W-1:0]        f;

  // Updating from the top index down lets each tap read the previous step's lower neighbour.
  always_comb begin
    st = rem_in;
    f  = '0;
    for (int s = 0; s < L; s++) begin
      f = st[R-1] ^ syms[s];
      for (int j = R - 1; j > 0; j--) begin
        st[j] = gf_mul(G[j], f) ^ st[j-1];
      end
      st[0] = gf_mul(G[0], f);
    end
  end

  assign rem_out = st;

endmodule

// File: rtl/rs_lfsr_enc_stream.sv
// Streaming systematic RS encoder: forwards DBEATS message beats, then appends
// PBEATS parity beats read out of the frozen LFSR remainder.
module rs_lfsr_enc_stream
  import rs_enc_pkg::*;
#(
  parameter int W = 10,
  parameter int N = 544,
  parameter int K = 522,
  parameter int L = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           flush_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [L*W-1:0] in_data_i,
  input  logic           in_last_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [L*W-1:0] out_data_o,
  output logic           out_last_o,
  output logic           out_is_parity_o,
  output logic           frame_err_o,
  output logic           busy_o
);

  localparam int R      = N - K;
  localparam int DBEATS = (K + L - 1) / L;
  localparam int PBEATS = (R + L - 1) / L;
  localparam int CW     = (DBEATS > 1) ? $clog2(DBEATS) : 1;
  localparam int PW     = (PBEATS > 1) ? $clog2(PBEATS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DBEATS - 1);
  localparam logic [PW-1:0] PAR_LAST = PW'(PBEATS - 1);

  state_e                   state;
  logic [CW-1:0]            cnt;
  logic [PW-1:0]            pcnt;
  logic [R-1:0][W-1:0]      rem;
  logic [R-1:0][W-1:0]      rem_base;
  logic [R-1:0][W-1:0]      rem_next;
  logic [PBEATS*L-1:0][W-1:0] par_sym;
  logic [PBEATS-1:0][L*W-1:0] par_beat;
  logic                     load_en;
  logic                     accept;
  logic                     at_last;

  assign load_en    = !out_valid_o || out_ready_i;
  assign in_ready_o = (state != PARITY) && load_en;
  assign accept     = in_valid_i && in_ready_o;
  assign at_last    = (cnt == CNT_LAST);
  assign busy_o     = (state != IDLE);

  // A new frame always starts from the zero remainder, so stale state never leaks across frames.
  assign rem_base = ((state == IDLE) || (cnt == '0)) ? '0 : rem;

  rs_lfsr_lstep #(
    .L(L)
  ) u_lstep (
    .rem_in (rem_base),
    .syms   (in_data_i),
    .rem_out(rem_next)
  );

  // Parity leaves highest-order remainder symbol first; tail slots of the last beat are zero.
  always_comb begin
    par_sym = '0;
    for (int i = 0; i < R; i++) begin
      par_sym[i] = rem[R-1-i];
    end
  end

  assign par_beat = par_sym;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= IDLE;
      cnt             <= '0;
      pcnt            <= '0;
      rem             <= '0;
      out_valid_o     <= 1'b0;
      out_data_o      <= '0;
      out_last_o      <= 1'b0;
      out_is_parity_o <= 1'b0;
      frame_err_o     <= 1'b0;
    end else if (flush_i) begin
      state           <= IDLE;
      cnt             <= '0;
      pcnt            <= '0;
      rem             <= '0;
      out_valid_o     <= 1'b0;
      out_data_o      <= '0;
      out_last_o      <= 1'b0;
      out_is_parity_o <= 1'b0;
      frame_err_o     <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      case (state)
        IDLE, DATA: begin
          if (accept) begin
            rem             <= rem_next;
            out_valid_o     <= 1'b1;
            out_data_o      <= in_data_i;
            out_last_o      <= 1'b0;
            out_is_parity_o <= 1'b0;
            frame_err_o     <= in_last_i ^ at_last;
            if (at_last) begin
              cnt   <= '0;
              pcnt  <= '0;
              state <= PARITY;
            end else begin
              cnt   <= cnt + CW'(1);
              state <= DATA;
            end
          end else if (load_en) begin
            out_valid_o <= 1'b0;
          end
        end
        PARITY: begin
          if (load_en) begin
            out_valid_o     <= 1'b1;
            out_data_o      <= par_beat[pcnt];
            out_is_parity_o <= 1'b1;
            out_last_o      <= (pcnt == PAR_LAST);
            if (pcnt == PAR_LAST) begin
              pcnt  <= '0;
              state <= IDLE;
            end else begin
              pcnt <= pcnt + PW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_lfsr_enc_stream.sv
// Scoreboard bench for rs_lfsr_enc_stream: directed frames driven beat by beat,
// expected beats queued from an independent GF/LFSR model and checked on transfer.
module tb_rs_lfsr_enc_stream;

  localparam int W      = 10;
  localparam int N      = 544;
  localparam int K      = 522;
  localparam int L      = 8;
  localparam int R      = N - K;
  localparam int DBEATS = (K + L - 1) / L;
  localparam int PAD    = DBEATS * L - K;
  localparam int PBEATS = (R + L - 1) / L;

  localparam logic [W-1:0] TAPS [R] = '{
    10'd807, 10'd280, 10'd944, 10'd621, 10'd3,   10'd177, 10'd365, 10'd657,
    10'd813, 10'd1010, 10'd712, 10'd466, 10'd374, 10'd544, 10'd374, 10'd482,
    10'd555, 10'd976, 10'd452, 10'd899, 10'd783, 10'd513
  };

  // Parity for a lone 1 in the final message symbol, in transmission order.
  localparam logic [W-1:0] DIR_PAR [R] = '{
    10'd513, 10'd783, 10'd899, 10'd452, 10'd976, 10'd555, 10'd482, 10'd374,
    10'd544, 10'd374, 10'd466, 10'd712, 10'd1010, 10'd813, 10'd657, 10'd365,
    10'd177, 10'd3,   10'd621, 10'd944, 10'd280, 10'd807
  };

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           flush_i = 1'b0;
  logic           in_valid_i = 1'b0;
  logic           in_ready_o;
  logic [L*W-1:0] in_data_i = '0;
  logic           in_last_i = 1'b0;
  logic           out_valid_o;
  logic           out_ready_i = 1'b1;
  logic [L*W-1:0] out_data_o;
  logic           out_last_o;
  logic           out_is_parity_o;
  logic           frame_err_o;
  logic           busy_o;

  typedef struct packed {
    logic [L*W-1:0] data;
    logic           last;
    logic           par;
  } beat_t;

  beat_t        exp_q[$];
  logic [W-1:0] msg [DBEATS][L];
  logic [W-1:0] mrem [R];
  int           tests_run = 0;
  int           tests_failed = 0;
  int           exp_err = 0;
  int           err_seen = 0;
  int           stall_cycles = 0;
  bit           rnd_ready = 1'b0;
  bit           count_stall = 1'b0;
  bit           directed_mode = 1'b0;

  rs_lfsr_enc_stream #(
    .W(W), .N(N), .K(K), .L(L)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_data_i      (in_data_i),
    .in_last_i      (in_last_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .out_last_o     (out_last_o),
    .out_is_parity_o(out_is_parity_o),
    .frame_err_o    (frame_err_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Carry-less product followed by top-down polynomial reduction.
  function automatic logic [W-1:0] gf_mul_tb(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-2:0] p;
    p = '0;
    for (int i = 0; i < W; i++)
      if (b[i]) p = p ^ ((2*W-1)'(a) << i);
    for (int i = 2*W-2; i >= W; i--)
      if (p[i]) p = p ^ ((2*W-1)'(11'h409) << (i - W));
    return p[W-1:0];
  endfunction

  function automatic logic [L*W-1:0] pack_beat(input int b);
    logic [L*W-1:0] v;
    for (int j = 0; j < L; j++) v[j*W +: W] = msg[b][j];
    return v;
  endfunction

  task automatic model_beat(input int b);
    logic [W-1:0] f;
    if (b == 0) for (int j = 0; j < R; j++) mrem[j] = '0;
    for (int s = 0; s < L; s++) begin
      f = mrem[R-1] ^ msg[b][s];
      for (int j = R - 1; j > 0; j--) mrem[j] = gf_mul_tb(TAPS[j], f) ^ mrem[j-1];
      mrem[0] = gf_mul_tb(TAPS[0], f);
    end
  endtask

  task automatic push_parity();
    beat_t e;
    int    idx;
    for (int p = 0; p < PBEATS; p++) begin
      e.data = '0;
      for (int j = 0; j < L; j++) begin
        idx = p * L + j;
        if (idx < R) e.data[j*W +: W] = directed_mode ? DIR_PAR[idx] : mrem[R-1-idx];
      end
      e.last = (p == PBEATS - 1);
      e.par  = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_msg(input bit random_data);
    for (int b = 0; b < DBEATS; b++)
      for (int j = 0; j < L; j++)
        msg[b][j] = (!random_data || (b * L + j < PAD)) ? '0 : W'($urandom_range(0, (1 << W) - 1));
  endtask

  // Called #1 after a rising edge; returns at the same phase after the beat is taken.
  task automatic apply_stimulus(input int b, input bit last_flag, input int gap);
    bit    accepted;
    int    n;
    beat_t e;
    repeat (gap) begin
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b1;
    in_data_i  = pack_beat(b);
    in_last_i  = last_flag;
    accepted   = 1'b0;
    n          = 0;
    while (!accepted && n < 200) begin
      @(negedge clk_i);
      accepted = in_ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    if (!accepted) begin
      check_output("accept_timeout", 128'(accepted), 128'(1));
    end else begin
      model_beat(b);
      e.data = pack_beat(b);
      e.last = 1'b0;
      e.par  = 1'b0;
      exp_q.push_back(e);
      if (last_flag != (b == DBEATS - 1)) exp_err++;
      if (b == DBEATS - 1) push_parity();
    end
  endtask

  task automatic send_frame(input bit err_mode, input int max_gap, input int stop_at);
    int  nb;
    bit  lf;
    nb = (stop_at < 0) ? DBEATS : stop_at + 1;
    for (int b = 0; b < nb; b++) begin
      lf = err_mode ? (b == 10) : (b == DBEATS - 1);
      apply_stimulus(b, lf, (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 1000) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    @(negedge clk_i);
    check_output({tag, "_queue_empty"}, 128'(exp_q.size()), 128'(0));
    check_output({tag, "_idle"}, 128'(busy_o), 128'(0));
    check_output({tag, "_frame_err_count"}, 128'(err_seen), 128'(exp_err));
    @(posedge clk_i);
    #1;
  endtask

  always @(posedge clk_i) begin
    #1;
    out_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk_i) begin
    beat_t e;
    if (rst_ni) begin
      if (frame_err_o) err_seen++;
      if (count_stall && !in_ready_o) stall_cycles++;
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $error("[TB] FAIL beat_extra: observed %0h expected no beat", out_data_o);
        end else begin
          e = exp_q.pop_front();
          check_output(out_is_parity_o ? "parity_beat" : "data_beat",
                       128'({out_data_o, out_last_o, out_is_parity_o}), 128'(e));
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_output("reset_out_valid", 128'(out_valid_o), 128'(0));
    check_output("reset_in_ready", 128'(in_ready_o), 128'(1));
    check_output("reset_busy", 128'(busy_o), 128'(0));
    check_output("reset_frame_err", 128'(frame_err_o), 128'(0));
    check_output("reset_out_data", 128'(out_data_o), 128'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    $display("[TB] all-zero frame");
    fill_msg(1'b0);
    send_frame(1'b0, 0, -1);
    wait_drain("zero_frame");

    $display("[TB] single symbol in last slot");
    fill_msg(1'b0);
    msg[DBEATS-1][L-1] = 10'd1;
    directed_mode = 1'b1;
    send_frame(1'b0, 0, -1);
    wait_drain("directed_frame");
    directed_mode = 1'b0;

    $display("[TB] random frames with backpressure and gaps");
    rnd_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      fill_msg(1'b1);
      send_frame(1'b0, 2, -1);
      wait_drain("random_frame");
    end
    rnd_ready = 1'b0;

    $display("[TB] misplaced in_last");
    fill_msg(1'b1);
    send_frame(1'b1, 0, -1);
    wait_drain("last_err_frame");
    check_output("last_err_pulses", 128'(err_seen), 128'(2));

    $display("[TB] flush mid-frame");
    fill_msg(1'b1);
    send_frame(1'b0, 0, 30);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    check_output("flush_out_valid", 128'(out_valid_o), 128'(0));
    check_output("flush_busy", 128'(busy_o), 128'(0));
    check_output("flush_queue_empty", 128'(exp_q.size()), 128'(0));
    @(posedge clk_i);
    #1;
    fill_msg(1'b1);
    send_frame(1'b0, 0, -1);
    wait_drain("post_flush_frame");

    $display("[TB] back-to-back frames");
    stall_cycles = 0;
    count_stall  = 1'b1;
    for (int f = 0; f < 3; f++) begin
      fill_msg(1'b1);
      send_frame(1'b0, 0, -1);
    end
    wait_drain("b2b_frames");
    count_stall = 1'b0;
    check_output("b2b_stall_cycles", 128'(stall_cycles), 128'(3 * PBEATS));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
